// File: rtl/clock_adjust_ctrl.sv
// Front-panel set-mode controller for the clock's hour/minute/second counters.
// Debounces the MODE/UP/DOWN keys, walks RUN->SET_HOUR->SET_MIN->SET_SEC, and issues
// one-cycle adjust strobes, a count-enable and a blink phase for the display.
module clock_adjust_ctrl #(
    parameter int unsigned DEB_CYCLES = 20000,
    parameter int unsigned TIMEOUT_S  = 10
) (
    input  logic       CP,
    input  logic       RST,
    input  logic       TICK_1HZ,
    input  logic       KEY_MODE,
    input  logic       KEY_UP,
    input  logic       KEY_DOWN,
    output logic       HOUR_CH,
    output logic       MIN_CH,
    output logic       SEC_CLR,
    output logic       ADJMODE,
    output logic       RUN_EN,
    output logic       BLINK,
    output logic [1:0] FIELD
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_S + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_S);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10,
        StSetSec  = 2'b11
    } state_t;

    // Bit 0 = MODE, bit 1 = UP, bit 2 = DOWN throughout the key path.
    logic [2:0]    key_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    level;
    logic [2:0]    press;
    logic [DW-1:0] deb_cnt [3];

    state_t        state;
    logic [TW-1:0] to_cnt;
    logic          ev_mode;
    logic          ev_down;
    logic          ev_adj;

    assign key_raw = {KEY_DOWN, KEY_UP, KEY_MODE};
    assign ev_mode = press[0];
    assign ev_down = press[2];
    // UP and DOWN together cancel each other out.
    assign ev_adj  = press[1] ^ press[2];
    assign FIELD   = state;

    // Synchronise each key, accept a new level after DEB_CYCLES stable cycles, flag 0->1 edges.
    always_ff @(posedge CP) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != level[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        level[i]   <= sync2[i];
                        press[i]   <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    // Any bounce back to the accepted level restarts the count.
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Set-mode FSM with registered strobes, count enable, blink phase and inactivity timeout.
    always_ff @(posedge CP) begin
        if (RST) begin
            state   <= StRun;
            to_cnt  <= '0;
            HOUR_CH <= 1'b0;
            MIN_CH  <= 1'b0;
            SEC_CLR <= 1'b0;
            ADJMODE <= 1'b0;
            RUN_EN  <= 1'b1;
            BLINK   <= 1'b0;
        end else begin
            HOUR_CH <= 1'b0;
            MIN_CH  <= 1'b0;
            SEC_CLR <= 1'b0;
            if (ev_mode) begin
                // MODE has priority over any coincident UP/DOWN.
                unique case (state)
                    StRun: begin
                        state  <= StSetHour;
                        RUN_EN <= 1'b0;
                    end
                    StSetHour: state <= StSetMin;
                    StSetMin:  state <= StSetSec;
                    StSetSec: begin
                        state  <= StRun;
                        RUN_EN <= 1'b1;
                    end
                endcase
                to_cnt <= '0;
                BLINK  <= 1'b0;
            end else if (state != StRun) begin
                if (ev_adj) begin
                    // An adjust wins over a coincident timeout expiry.
                    to_cnt <= '0;
                    unique case (state)
                        StSetHour: begin
                            HOUR_CH <= 1'b1;
                            ADJMODE <= ev_down;
                        end
                        StSetMin: begin
                            MIN_CH  <= 1'b1;
                            ADJMODE <= ev_down;
                        end
                        StSetSec: SEC_CLR <= 1'b1;
                        default: ;
                    endcase
                    if (TICK_1HZ) begin
                        BLINK <= ~BLINK;
                    end
                end else if (to_cnt == TO_LIMIT) begin
                    state  <= StRun;
                    RUN_EN <= 1'b1;
                    to_cnt <= '0;
                    BLINK  <= 1'b0;
                end else if (TICK_1HZ) begin
                    to_cnt <= to_cnt + TW'(1);
                    BLINK  <= ~BLINK;
                end
            end
        end
    end

endmodule
